// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary signals: decode-side inputs, EX-side registered outputs,
// and the Stall back-pressure line driven by the stage.
interface id_ex_stage_if;
  // Protocol: the stage never blocks on the ID side. It captures every cycle
  // unless Flush or a load-use hazard forces a bubble. Stall=1 tells upstream
  // to hold PC and IF/ID for that cycle. Flush always wins over Stall.
  logic [14:0] ID_Ctrl;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] ID_Imm;
  logic [31:0] ID_PC4;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  ID_Rd;
  logic        Flush;
  logic [14:0] EX_Ctrl;
  logic [31:0] EX_ReadData1;
  logic [31:0] EX_ReadData2;
  logic [31:0] EX_Imm;
  logic [31:0] EX_PC4;
  logic [4:0]  EX_Rs;
  logic [4:0]  EX_Rt;
  logic [4:0]  EX_Rd;
  logic        EX_Valid;
  logic        Stall;

  modport master (
    output ID_Ctrl, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
    output ID_Rs, ID_Rt, ID_Rd, Flush,
    input  EX_Ctrl, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
    input  EX_Rs, EX_Rt, EX_Rd, EX_Valid, Stall
  );

  modport slave (
    input  ID_Ctrl, ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC4,
    input  ID_Rs, ID_Rt, ID_Rd, Flush,
    output EX_Ctrl, EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC4,
    output EX_Rs, EX_Rt, EX_Rd, EX_Valid, Stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush-to-bubble.
// Optional macro ID_EX_STALL_STATS_EN adds a saturating 16-bit StallCount output.
module id_ex_stage (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_STATS_EN
  ,
  output logic [15:0]  StallCount
`endif
);

  logic [14:0] ctrl_q, ctrl_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc4_q, pc4_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;
  logic        hazard;

  // Load in EX writing a real register that decode wants to read.
  always_comb begin
    hazard = valid_q & ctrl_q[9] & (rt_q != 5'd0) &
             ((rt_q == bus.ID_Rs) | (rt_q == bus.ID_Rt));
  end

  assign bus.Stall = hazard & ~bus.Flush;

  always_comb begin
    ctrl_d  = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    pc4_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    valid_d = 1'b0;
    if (!bus.Flush && !hazard) begin
      ctrl_d  = bus.ID_Ctrl;
      rd1_d   = bus.ID_ReadData1;
      rd2_d   = bus.ID_ReadData2;
      imm_d   = bus.ID_Imm;
      pc4_d   = bus.ID_PC4;
      rs_d    = bus.ID_Rs;
      rt_d    = bus.ID_Rt;
      rd_d    = bus.ID_Rd;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.EX_Ctrl      = ctrl_q;
  assign bus.EX_ReadData1 = rd1_q;
  assign bus.EX_ReadData2 = rd2_q;
  assign bus.EX_Imm       = imm_q;
  assign bus.EX_PC4       = pc4_q;
  assign bus.EX_Rs        = rs_q;
  assign bus.EX_Rt        = rt_q;
  assign bus.EX_Rd        = rd_q;
  assign bus.EX_Valid     = valid_q;

`ifdef ID_EX_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, then random traffic against a
// behavioural model of the EX register contents and the stall rule.
module tb_id_ex_stage;
  localparam int W = 159;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
`ifdef ID_EX_STALL_STATS_EN
  logic [15:0] stall_count;
`endif

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ID_EX_STALL_STATS_EN
    ,
    .StallCount (stall_count)
`endif
  );

  typedef struct {
    logic [14:0] ctrl;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } ex_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [14:0] ctrl;
    logic [4:0]  rs, rt;
    logic [31:0] imm;
    logic        exp_stall;
    logic        exp_valid;
    logic [14:0] exp_ctrl;
  } vec_t;

  ex_t             m;
  int              total = 0;
  int              bad = 0;
  int unsigned     stat_model = 0;
  logic [W-1:0]    exp_q[$];
  vec_t            vt[12];

  function automatic logic [W-1:0] pack(ex_t e);
    return {e.ctrl, e.rd1, e.rd2, e.imm, e.pc4, e.rs, e.rt, e.rd, e.valid};
  endfunction

  function automatic logic [W-1:0] pack_dut();
    return {bus.EX_Ctrl, bus.EX_ReadData1, bus.EX_ReadData2, bus.EX_Imm,
            bus.EX_PC4, bus.EX_Rs, bus.EX_Rt, bus.EX_Rd, bus.EX_Valid};
  endfunction

  // Decode reads the destination of a load still sitting in EX.
  function automatic logic model_hazard();
    logic load_in_ex;
    load_in_ex = m.valid && m.ctrl[9];
    return load_in_ex && (m.rt != 0) && (m.rt == bus.ID_Rs || m.rt == bus.ID_Rt);
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pre_edge();
    logic hz;
    @(negedge clk);
    hz = model_hazard();
    check("stall", W'(bus.Stall), W'(hz && !bus.Flush));
    if (reset) stat_model = 0;
    else if (hz && !bus.Flush && stat_model < 16'hFFFF) stat_model++;
    if (reset || bus.Flush || hz) begin
      m = '{default: '0};
    end else begin
      m.ctrl = bus.ID_Ctrl;      m.rd1 = bus.ID_ReadData1;
      m.rd2 = bus.ID_ReadData2;  m.imm = bus.ID_Imm;
      m.pc4 = bus.ID_PC4;        m.rs = bus.ID_Rs;
      m.rt = bus.ID_Rt;          m.rd = bus.ID_Rd;
      m.valid = 1'b1;
    end
    exp_q.push_back(pack(m));
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    check("ex_state", pack_dut(), exp_q.pop_front());
`ifdef ID_EX_STALL_STATS_EN
    check("stall_count", W'(stall_count), W'(stat_model));
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.ID_Ctrl = '0; bus.ID_ReadData1 = '0; bus.ID_ReadData2 = '0;
    bus.ID_Imm = '0; bus.ID_PC4 = '0; bus.ID_Rs = '0; bus.ID_Rt = '0;
    bus.ID_Rd = '0; bus.Flush = 1'b0;
    m = '{default: '0};

    vt[0]  = '{1'b1, 1'b0, 15'h1408, 5'd8, 5'd0, 32'd5, 1'b0, 1'b0, 15'h0000};
    vt[1]  = '{1'b0, 1'b0, 15'h1408, 5'd8, 5'd0, 32'd5, 1'b0, 1'b1, 15'h1408};
    vt[2]  = '{1'b0, 1'b0, 15'h1E23, 5'd0, 5'd9, 32'd0, 1'b0, 1'b1, 15'h1E23};
    vt[3]  = '{1'b0, 1'b0, 15'h1408, 5'd9, 5'd0, 32'd7, 1'b1, 1'b0, 15'h0000};
    vt[4]  = '{1'b0, 1'b0, 15'h1408, 5'd9, 5'd0, 32'd7, 1'b0, 1'b1, 15'h1408};
    vt[5]  = '{1'b0, 1'b0, 15'h1E23, 5'd0, 5'd0, 32'd4, 1'b0, 1'b1, 15'h1E23};
    vt[6]  = '{1'b0, 1'b0, 15'h1408, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1, 15'h1408};
    vt[7]  = '{1'b0, 1'b0, 15'h1E23, 5'd3, 5'd9, 32'd8, 1'b0, 1'b1, 15'h1E23};
    vt[8]  = '{1'b0, 1'b1, 15'h1408, 5'd2, 5'd9, 32'd2, 1'b0, 1'b0, 15'h0000};
    vt[9]  = '{1'b0, 1'b0, 15'h1E23, 5'd1, 5'd9, 32'd3, 1'b0, 1'b1, 15'h1E23};
    vt[10] = '{1'b1, 1'b0, 15'h1408, 5'd9, 5'd0, 32'd6, 1'b1, 1'b0, 15'h0000};
    vt[11] = '{1'b0, 1'b0, 15'h1408, 5'd9, 5'd0, 32'd6, 1'b0, 1'b1, 15'h1408};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack_dut(), pack(m));
    check("reset_stall", W'(bus.Stall), W'(1'b0));

    for (int i = 0; i < 12; i++) begin
      reset = vt[i].rst;
      bus.Flush = vt[i].flush;
      bus.ID_Ctrl = vt[i].ctrl;
      bus.ID_Rs = vt[i].rs;
      bus.ID_Rt = vt[i].rt;
      bus.ID_Rd = 5'(i);
      bus.ID_Imm = vt[i].imm;
      bus.ID_ReadData1 = 32'h1000 + i;
      bus.ID_ReadData2 = 32'h2000 + i;
      bus.ID_PC4 = 32'(4 * i + 4);
      pre_edge();
      check($sformatf("vec%0d_stall", i), W'(bus.Stall), W'(vt[i].exp_stall));
      post_edge();
      check($sformatf("vec%0d_valid", i), W'(bus.EX_Valid), W'(vt[i].exp_valid));
      check($sformatf("vec%0d_ctrl", i), W'(bus.EX_Ctrl), W'(vt[i].exp_ctrl));
    end

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      bus.ID_Ctrl = 15'($urandom);
      bus.ID_Rs = 5'($urandom_range(0, 3));
      bus.ID_Rt = 5'($urandom_range(0, 3));
      bus.ID_Rd = 5'($urandom);
      bus.ID_ReadData1 = $urandom;
      bus.ID_ReadData2 = $urandom;
      bus.ID_Imm = $urandom;
      bus.ID_PC4 = $urandom;
      pre_edge();
      post_edge();
    end

`ifdef ID_EX_STALL_STATS_EN
    reset = 1'b0;
    bus.Flush = 1'b0;
    bus.ID_Rs = 5'd9;
    force dut.valid_q = 1'b1;
    force dut.ctrl_q = 15'h0200;
    force dut.rt_q = 5'd9;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_count_sat", W'(stall_count), W'(16'hFFFF));
    release dut.valid_q;
    release dut.ctrl_q;
    release dut.rt_q;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("stall_count_reset", W'(stall_count), W'(16'h0000));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
